// File: rtl/ffd_shift_load_reg.sv
// SIPO/PIPO shift register: one 2:1 mux (shift vs. load) per D flop, plus a free-running
// divider whose registered tick can act as the register's clock enable for slow demos.
module ffd_shift_load_reg #(
   parameter int WIDTH   = 4,
   parameter int DIV_MAX = 25_000_000,
   parameter bit USE_DIV = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             serialin_i,
   input  logic             move_load_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o,
   output logic             serialout_o,
   output logic             tick_o
);

   localparam int            CW       = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DIV_MAX - 1);

   logic [CW-1:0]    r_cnt;
   logic             r_tick;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_next;
   logic             w_en;

   // Divider keeps counting regardless of USE_DIV so tick_o is always observable.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
         r_tick <= (r_cnt == CNT_LAST);
      end
   end

   assign w_en = USE_DIV ? r_tick : 1'b1;

   // Per-stage mux: shift takes the upstream neighbour (serial input at the MSB), load takes d_i.
   for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      if (i == WIDTH - 1) begin : g_msb
         assign w_next[i] = move_load_i ? serialin_i : d_i[i];
      end else begin : g_mid
         assign w_next[i] = move_load_i ? r_q[i+1] : d_i[i];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     r_q <= '0;
      else if (w_en) r_q <= w_next;
   end

   assign q_o         = r_q;
   assign serialout_o = r_q[0];
   assign tick_o      = r_tick;

endmodule

// File: tb/tb_ffd_shift_load_reg.sv
// Directed bench: dut0 updates every edge, dut1 is gated by its divider tick (DIV_MAX=4).
module tb_ffd_shift_load_reg;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       si0 = 1'b0, ml0 = 1'b0;
   logic [3:0] d0  = 4'b0000;
   logic       si1 = 1'b0, ml1 = 1'b0;
   logic [3:0] d1  = 4'b0000;
   logic [3:0] q0, q1;
   logic       so0, so1, tk0, tk1;

   int n_tests = 0;
   int n_fail  = 0;

   ffd_shift_load_reg #(.WIDTH(4), .DIV_MAX(4), .USE_DIV(1'b0)) dut0 (
      .clk_i(clk), .rst_i(rst), .serialin_i(si0), .move_load_i(ml0),
      .d_i(d0), .q_o(q0), .serialout_o(so0), .tick_o(tk0));

   ffd_shift_load_reg #(.WIDTH(4), .DIV_MAX(4), .USE_DIV(1'b1)) dut1 (
      .clk_i(clk), .rst_i(rst), .serialin_i(si1), .move_load_i(ml1),
      .d_i(d1), .q_o(q1), .serialout_o(so1), .tick_o(tk1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One edge of dut0 shift/load, checking q_o and serialout_o.
   task automatic op0(input string tag, input logic ml, input logic si, input logic [3:0] d,
                      input logic [3:0] exp_q);
      ml0 = ml; si0 = si; d0 = d;
      step();
      chk({tag, ".q"}, q0, exp_q);
      chk({tag, ".so"}, {3'b000, so0}, {3'b000, exp_q[0]});
   endtask

   initial begin
      // Power-up reset, applied between edges.
      #1 rst = 1'b1;
      #2;
      chk("por.q0", q0, 4'b0000);
      chk("por.q1", q1, 4'b0000);
      chk("por.tick", {2'b00, tk1, tk0}, 4'b0000);
      #7 rst = 1'b0;                          // t=10, next edge at 15

      // Divider: tick on the 4th edge after release, gated load on the 5th.
      d1 = 4'b1111; ml1 = 1'b0;
      step(); chk("div.e1.tick", {2'b00, tk1, tk0}, 4'b0000); chk("div.e1.q1", q1, 4'b0000);
      step(); chk("div.e2.tick", {2'b00, tk1, tk0}, 4'b0000); chk("div.e2.q1", q1, 4'b0000);
      step(); chk("div.e3.tick", {2'b00, tk1, tk0}, 4'b0000); chk("div.e3.q1", q1, 4'b0000);
      step(); chk("div.e4.tick", {2'b00, tk1, tk0}, 4'b0011); chk("div.e4.q1", q1, 4'b0000);
      step(); chk("div.e5.tick", {2'b00, tk1, tk0}, 4'b0000); chk("div.e5.q1", q1, 4'b1111);
      d1 = 4'b0101;
      step(); chk("div.e6.q1", q1, 4'b1111);
      step(); chk("div.e7.q1", q1, 4'b1111);
      step(); chk("div.e8.q1", q1, 4'b1111); chk("div.e8.tick", {2'b00, tk1, tk0}, 4'b0011);
      step(); chk("div.e9.q1", q1, 4'b0101); chk("div.e9.tick", {2'b00, tk1, tk0}, 4'b0000);

      // Parallel load, with d_i changing while loading.
      op0("load.a", 1'b0, 1'b0, 4'b1010, 4'b1010);
      op0("load.b", 1'b0, 1'b0, 4'b0011, 4'b0011);

      // Serial shift from 0000.
      op0("shift.clr", 1'b0, 1'b0, 4'b0000, 4'b0000);
      op0("shift.1", 1'b1, 1'b1, 4'b1111, 4'b1000);
      op0("shift.2", 1'b1, 1'b0, 4'b1111, 4'b0100);
      op0("shift.3", 1'b1, 1'b1, 4'b1111, 4'b1010);
      op0("shift.4", 1'b1, 1'b1, 4'b1111, 4'b1101);

      // Mixed load/shift.
      op0("mix.ld", 1'b0, 1'b1, 4'b0110, 4'b0110);
      op0("mix.s1", 1'b1, 1'b0, 4'b1111, 4'b0011);
      op0("mix.s2", 1'b1, 1'b0, 4'b1111, 4'b0001);
      op0("mix.ld2", 1'b0, 1'b1, 4'b1001, 4'b1001);

      // Asynchronous reset mid-cycle from 1111, no clock edge needed.
      op0("rst.pre", 1'b0, 1'b0, 4'b1111, 4'b1111);
      #2 rst = 1'b1;
      #1;
      chk("rst.async.q0", q0, 4'b0000);
      chk("rst.async.q1", q1, 4'b0000);
      chk("rst.async.tick", {2'b00, tk1, tk0}, 4'b0000);
      step();
      chk("rst.hold.q0", q0, 4'b0000);
      chk("rst.hold.tick", {2'b00, tk1, tk0}, 4'b0000);
      #4 rst = 1'b0;

      // Shifting after release acts on the cleared state; dut1 ticks 4 edges later.
      op0("post.1", 1'b1, 1'b1, 4'b0000, 4'b1000); chk("post.1.tick", {3'b000, tk1}, 4'b0000);
      op0("post.2", 1'b1, 1'b0, 4'b0000, 4'b0100); chk("post.2.tick", {3'b000, tk1}, 4'b0000);
      op0("post.3", 1'b1, 1'b0, 4'b0000, 4'b0010); chk("post.3.tick", {3'b000, tk1}, 4'b0000);
      chk("post.3.q1", q1, 4'b0000);
      op0("post.4", 1'b1, 1'b0, 4'b0000, 4'b0001); chk("post.4.tick", {3'b000, tk1}, 4'b0001);
      chk("post.4.q1", q1, 4'b0000);
      op0("post.5", 1'b1, 1'b0, 4'b0000, 4'b0000); chk("post.5.q1", q1, 4'b0101);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
